// File: rtl/led_seq_ctrl_if.sv
// Configuration channel for the LED sequencer: a valid/ready request
// carrying a pattern mode and a step period.
interface led_seq_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_period;

  modport master (output cfg_valid, output cfg_mode, output cfg_period, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_mode, input cfg_period, output cfg_ready);
endinterface

// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: prescaler-driven step enable, mode FSM (RUN/HOLD/APPLY),
// and pattern generator producing registered active-low LED drive.
module led_seq_ctrl #(
  parameter int unsigned CLK_DIV = 10000000,
  parameter int          CNT_W   = 32,
  parameter int          LED_W   = 4
) (
  input  logic             clk,
  input  logic             nrst,
  led_seq_ctrl_if.slave    cfg,
  input  logic             pause,
  output logic [LED_W-1:0] led,
  output logic             step_tick,
  output logic [2:0]       mode_cur
);

  typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_APPLY} state_t;

  localparam logic [2:0]       MODE_ROT_L  = 3'd1;
  localparam logic [2:0]       MODE_ROT_R  = 3'd2;
  localparam logic [2:0]       MODE_BOUNCE = 3'd3;
  localparam logic [2:0]       MODE_BLINK  = 3'd4;
  localparam logic [2:0]       MODE_COUNT  = 3'd5;
  localparam logic             DIR_UP      = 1'b0;
  localparam logic             DIR_DN      = 1'b1;
  localparam logic [CNT_W-1:0] PERIOD_DEF  = CNT_W'(CLK_DIV);
  localparam logic [LED_W-1:0] POS_LAST    = LED_W'(LED_W - 1);
  localparam logic [LED_W-1:0] POS_ONE     = LED_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_presc;
  logic [CNT_W-1:0] r_period;
  logic [LED_W-1:0] r_pos;
  logic             r_dir;
  logic [LED_W-1:0] r_led;
  logic             r_tick;
  logic [2:0]       r_mode;
  logic [2:0]       r_mode_pend;

  logic             w_ready;
  logic             w_accept;
  logic             w_count_en;
  logic             w_terminal;
  logic [LED_W-1:0] w_pos_next;
  logic             w_dir_next;
  logic [2:0]       w_sel_mode;
  logic [LED_W-1:0] w_sel_pos;
  logic [LED_W-1:0] w_onehot;
  logic [LED_W-1:0] w_onehot_rev;
  logic [LED_W-1:0] w_led_next;

  assign w_ready    = (r_state != ST_APPLY);
  assign w_accept   = cfg.cfg_valid & w_ready;
  // A request or a pause in the terminal cycle swallows that step.
  assign w_count_en = (r_state == ST_RUN) & ~w_accept & ~pause;
  assign w_terminal = (r_presc == r_period - CNT_W'(1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_accept)   w_state_next = ST_APPLY;
        else if (pause) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_accept)    w_state_next = ST_APPLY;
        else if (!pause) w_state_next = ST_RUN;
      end
      ST_APPLY: begin
        w_state_next = pause ? ST_HOLD : ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  always_comb begin
    w_pos_next = r_pos;
    w_dir_next = r_dir;
    case (r_mode)
      MODE_ROT_L, MODE_ROT_R: begin
        w_pos_next = (r_pos == POS_LAST) ? '0 : r_pos + POS_ONE;
      end
      MODE_BOUNCE: begin
        if (r_dir == DIR_UP) begin
          if (r_pos == POS_LAST) begin
            w_pos_next = r_pos - POS_ONE;
            w_dir_next = DIR_DN;
          end else begin
            w_pos_next = r_pos + POS_ONE;
          end
        end else begin
          if (r_pos == '0) begin
            w_pos_next = r_pos + POS_ONE;
            w_dir_next = DIR_UP;
          end else begin
            w_pos_next = r_pos - POS_ONE;
          end
        end
      end
      MODE_BLINK: w_pos_next = r_pos ^ POS_ONE;
      MODE_COUNT: w_pos_next = r_pos + POS_ONE;
      default:    w_pos_next = r_pos;
    endcase
  end

  // During APPLY the generator shows the first pattern of the pending mode.
  assign w_sel_mode = (r_state == ST_APPLY) ? r_mode_pend : r_mode;
  assign w_sel_pos  = (r_state == ST_APPLY) ? '0 : w_pos_next;
  assign w_onehot   = POS_ONE << w_sel_pos;

  genvar gi;
  generate
    for (gi = 0; gi < LED_W; gi++) begin : g_rev
      assign w_onehot_rev[gi] = w_onehot[LED_W-1-gi];
    end
  endgenerate

  always_comb begin
    w_led_next = '1;
    case (w_sel_mode)
      MODE_ROT_L, MODE_BOUNCE: w_led_next = ~w_onehot;
      MODE_ROT_R:              w_led_next = ~w_onehot_rev;
      MODE_BLINK:              w_led_next = {LED_W{w_sel_pos[0]}};
      MODE_COUNT:              w_led_next = ~w_sel_pos;
      default:                 w_led_next = '1;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_presc     <= '0;
      r_period    <= PERIOD_DEF;
      r_pos       <= '0;
      r_dir       <= DIR_UP;
      r_led       <= '1;
      r_tick      <= 1'b0;
      r_mode      <= 3'd0;
      r_mode_pend <= 3'd0;
    end else begin
      r_tick <= 1'b0;
      if (w_accept) begin
        r_mode_pend <= cfg.cfg_mode;
        r_period    <= (cfg.cfg_period == '0) ? PERIOD_DEF : cfg.cfg_period;
      end
      if (r_state == ST_APPLY) begin
        r_presc <= '0;
        r_pos   <= '0;
        r_dir   <= DIR_UP;
        r_mode  <= r_mode_pend;
        r_led   <= w_led_next;
      end else if (w_count_en) begin
        if (w_terminal) begin
          r_presc <= '0;
          r_pos   <= w_pos_next;
          r_dir   <= w_dir_next;
          r_led   <= w_led_next;
          r_tick  <= 1'b1;
        end else begin
          r_presc <= r_presc + CNT_W'(1);
        end
      end
    end
  end

  assign cfg.cfg_ready = w_ready;
  assign led           = r_led;
  assign step_tick     = r_tick;
  assign mode_cur      = r_mode;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: expected steps are queued when a
// scenario is set up and popped as each step_tick appears.
module tb_led_seq_ctrl;
  localparam int CNT_W = 32;
  localparam int LED_W = 4;
  localparam int DIV   = 4;

  logic             clk   = 1'b0;
  logic             nrst  = 1'b0;
  logic             pause = 1'b0;
  logic [LED_W-1:0] led;
  logic             step_tick;
  logic [2:0]       mode_cur;

  led_seq_ctrl_if #(.CNT_W(CNT_W)) cfg_bus ();

  led_seq_ctrl #(.CLK_DIV(DIV), .CNT_W(CNT_W), .LED_W(LED_W)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .cfg       (cfg_bus),
    .pause     (pause),
    .led       (led),
    .step_tick (step_tick),
    .mode_cur  (mode_cur)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LED_W-1:0] led;
    int               gap;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for the next step_tick, sampling on falling edges.
  task automatic wait_tick(input int max_cyc, output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (step_tick === 1'b1) got = 1'b1;
    end
  endtask

  // Issues one configuration request from a falling edge and checks APPLY.
  task automatic apply_cfg(input logic [2:0] mode, input logic [CNT_W-1:0] period,
                           input logic [LED_W-1:0] exp_led, input string name);
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_mode   = mode;
    cfg_bus.cfg_period = period;
    @(negedge clk);
    cfg_bus.cfg_valid  = 1'b0;
    checks++;
    if (cfg_bus.cfg_ready !== 1'b0 || step_tick !== 1'b0) begin
      errors++;
      $display("FAIL %s apply_cycle: ready=%b tick=%b, expected ready=0 tick=0",
               name, cfg_bus.cfg_ready, step_tick);
    end
    @(negedge clk);
    checks++;
    if (led !== exp_led || mode_cur !== mode || cfg_bus.cfg_ready !== 1'b1 || step_tick !== 1'b0) begin
      errors++;
      $display("FAIL %s after_apply: led=%b mode=%0d ready=%b tick=%b, expected led=%b mode=%0d ready=1 tick=0",
               name, led, mode_cur, cfg_bus.cfg_ready, step_tick, exp_led, mode);
    end else begin
      $display("cfg %s mode=%0d period=%0d led=%b", name, mode, period, led);
    end
  endtask

  task automatic test_reset();
    int   cyc;
    bit   got;
    exp_t e;
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_mode   = 3'd0;
    cfg_bus.cfg_period = '0;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (led !== 4'b1111 || mode_cur !== 3'd0 || cfg_bus.cfg_ready !== 1'b1 || step_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: led=%b mode=%0d ready=%b tick=%b, expected 1111 0 1 0",
               led, mode_cur, cfg_bus.cfg_ready, step_tick);
    end
    nrst = 1'b1;
    repeat (3) sb_q.push_back('{led: 4'b1111, gap: DIV});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      wait_tick(e.gap + 2, cyc, got);
      checks++;
      if (!got || cyc != e.gap || led !== e.led || mode_cur !== 3'd0) begin
        errors++;
        $display("FAIL reset_step: got=%0d gap=%0d led=%b mode=%0d, expected gap=%0d led=%b mode=0",
                 got, cyc, led, mode_cur, e.gap, e.led);
      end else $display("step reset led=%b gap=%0d", led, cyc);
    end
  endtask

  task automatic test_rot_l();
    int   cyc;
    bit   got;
    exp_t e;
    logic [LED_W-1:0] seq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    apply_cfg(3'd1, 32'd3, 4'b1110, "rot_l");
    foreach (seq[i]) sb_q.push_back('{led: seq[i], gap: 3});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      wait_tick(e.gap + 2, cyc, got);
      checks++;
      if (!got || cyc != e.gap || led !== e.led) begin
        errors++;
        $display("FAIL rot_l_step: got=%0d gap=%0d led=%b, expected gap=%0d led=%b",
                 got, cyc, led, e.gap, e.led);
      end else $display("step rot_l led=%b gap=%0d", led, cyc);
    end
  endtask

  task automatic test_bounce();
    int   cyc;
    bit   got;
    exp_t e;
    logic [LED_W-1:0] seq [7] = '{4'b1101, 4'b1011, 4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1101};
    apply_cfg(3'd3, 32'd1, 4'b1110, "bounce");
    foreach (seq[i]) sb_q.push_back('{led: seq[i], gap: 1});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      wait_tick(e.gap + 2, cyc, got);
      checks++;
      if (!got || cyc != e.gap || led !== e.led) begin
        errors++;
        $display("FAIL bounce_step: got=%0d gap=%0d led=%b, expected gap=%0d led=%b",
                 got, cyc, led, e.gap, e.led);
      end else $display("step bounce led=%b gap=%0d", led, cyc);
    end
  endtask

  task automatic test_count_pause();
    int   cyc;
    bit   got;
    exp_t e;
    apply_cfg(3'd5, 32'd2, 4'b1111, "count");
    for (int i = 1; i <= 8; i++) sb_q.push_back('{led: 4'(~i), gap: 2});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      wait_tick(e.gap + 2, cyc, got);
      checks++;
      if (!got || cyc != e.gap || led !== e.led) begin
        errors++;
        $display("FAIL count_step: got=%0d gap=%0d led=%b, expected gap=%0d led=%b",
                 got, cyc, led, e.gap, e.led);
      end else $display("step count led=%b gap=%0d", led, cyc);
    end
    // Raise pause in the terminal-count cycle: that step must not happen.
    @(negedge clk);
    pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (step_tick !== 1'b0 || led !== 4'b0111) begin
        errors++;
        $display("FAIL pause_hold: cycle=%0d tick=%b led=%b, expected tick=0 led=0111",
                 k, step_tick, led);
      end
    end
    $display("pause held 10 cycles led=%b", led);
    pause = 1'b0;
    // Held at period-1: one cycle to leave HOLD, then the terminal count.
    for (int i = 9; i <= 15; i++) sb_q.push_back('{led: 4'(~i), gap: 2});
    sb_q.push_back('{led: 4'b1111, gap: 2});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      wait_tick(e.gap + 2, cyc, got);
      checks++;
      if (!got || cyc != e.gap || led !== e.led) begin
        errors++;
        $display("FAIL count_resume_step: got=%0d gap=%0d led=%b, expected gap=%0d led=%b",
                 got, cyc, led, e.gap, e.led);
      end else $display("step count led=%b gap=%0d", led, cyc);
    end
  endtask

  task automatic test_cfg_terminal();
    int   cyc;
    bit   got;
    exp_t e;
    // Count mode period 2: the cycle after a tick is the terminal cycle.
    @(negedge clk);
    checks++;
    if (step_tick !== 1'b0 || led !== 4'b1111) begin
      errors++;
      $display("FAIL pre_terminal: tick=%b led=%b, expected tick=0 led=1111", step_tick, led);
    end
    apply_cfg(3'd4, 32'd5, 4'b0000, "blink_at_terminal");
    sb_q.push_back('{led: 4'b1111, gap: 5});
    sb_q.push_back('{led: 4'b0000, gap: 5});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      wait_tick(e.gap + 2, cyc, got);
      checks++;
      if (!got || cyc != e.gap || led !== e.led) begin
        errors++;
        $display("FAIL blink_step: got=%0d gap=%0d led=%b, expected gap=%0d led=%b",
                 got, cyc, led, e.gap, e.led);
      end else $display("step blink led=%b gap=%0d", led, cyc);
    end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    bit   got;
    int   accepts = 0;
    exp_t e;
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_mode   = 3'd2;
    cfg_bus.cfg_period = 32'd3;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (cfg_bus.cfg_ready !== logic'(k % 2 == 0) || step_tick !== 1'b0 ||
          (k % 2 == 0 && (led !== 4'b0111 || mode_cur !== 3'd2))) begin
        errors++;
        $display("FAIL b2b_cycle: k=%0d ready=%b tick=%b led=%b mode=%0d, expected ready=%0d tick=0 led=0111 mode=2",
                 k, cfg_bus.cfg_ready, step_tick, led, mode_cur, (k % 2 == 0));
      end else if (cfg_bus.cfg_ready === 1'b0) begin
        accepts++;
        $display("b2b accept %0d at cycle %0d", accepts, k);
      end
    end
    cfg_bus.cfg_valid = 1'b0;
    sb_q.push_back('{led: 4'b1011, gap: 3});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      wait_tick(e.gap + 2, cyc, got);
      checks++;
      if (!got || cyc != e.gap || led !== e.led) begin
        errors++;
        $display("FAIL rot_r_step: got=%0d gap=%0d led=%b, expected gap=%0d led=%b",
                 got, cyc, led, e.gap, e.led);
      end else $display("step rot_r led=%b gap=%0d", led, cyc);
    end
  endtask

  task automatic test_async_reset();
    int   cyc;
    bit   got;
    exp_t e;
    // Reset in the middle of the APPLY cycle.
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_mode   = 3'd2;
    cfg_bus.cfg_period = 32'd3;
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (led !== 4'b1111 || cfg_bus.cfg_ready !== 1'b1 || mode_cur !== 3'd0 || step_tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_apply: led=%b ready=%b mode=%0d tick=%b, expected 1111 1 0 0",
               led, cfg_bus.cfg_ready, mode_cur, step_tick);
    end else $display("async reset during APPLY led=%b", led);
    @(negedge clk);
    nrst = 1'b1;
    sb_q.push_back('{led: 4'b1111, gap: DIV});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      wait_tick(e.gap + 2, cyc, got);
      checks++;
      if (!got || cyc != e.gap || led !== e.led) begin
        errors++;
        $display("FAIL post_reset_step: got=%0d gap=%0d led=%b, expected gap=%0d led=%b",
                 got, cyc, led, e.gap, e.led);
      end else $display("step post_reset led=%b gap=%0d", led, cyc);
    end
    // Reset part-way through a step period with ROT_R running.
    apply_cfg(3'd2, 32'd3, 4'b0111, "rot_r");
    sb_q.push_back('{led: 4'b1011, gap: 3});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      wait_tick(e.gap + 2, cyc, got);
      checks++;
      if (!got || cyc != e.gap || led !== e.led) begin
        errors++;
        $display("FAIL rot_r_pre_reset: got=%0d gap=%0d led=%b, expected gap=%0d led=%b",
                 got, cyc, led, e.gap, e.led);
      end else $display("step rot_r led=%b gap=%0d", led, cyc);
    end
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (led !== 4'b1111 || cfg_bus.cfg_ready !== 1'b1 || mode_cur !== 3'd0 || step_tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_period: led=%b ready=%b mode=%0d tick=%b, expected 1111 1 0 0",
               led, cfg_bus.cfg_ready, mode_cur, step_tick);
    end else $display("async reset mid-period led=%b", led);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    sb_q.push_back('{led: 4'b1111, gap: DIV});
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      wait_tick(e.gap + 2, cyc, got);
      checks++;
      if (!got || cyc != e.gap || led !== e.led) begin
        errors++;
        $display("FAIL post_reset2_step: got=%0d gap=%0d led=%b, expected gap=%0d led=%b",
                 got, cyc, led, e.gap, e.led);
      end else $display("step post_reset2 led=%b gap=%0d", led, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_rot_l();
    test_bounce();
    test_count_pause();
    test_cfg_terminal();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Sequencer/controller for the board LED bank.
- A single-clock prescaler produces a step enable, so there is no derived clock.
- A small mode FSM chooses the LED pattern, advances it on each step, and accepts new mode/period settings over a valid/ready handshake.
- Sits between the top-level control logic (buttons/host registers) and the LED pins.

Parameters:
- CLK_DIV, 10000000, default clk cycles per pattern step; also used when cfg_period = 0.
- CNT_W, 32, prescaler and period width.
- LED_W, 4, number of LEDs; LEDs are active-low (0 = lit).

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- nrst, input, 1, asynchronous active-low reset.
- cfg_valid, input, 1, configuration request.
- cfg_ready, output, 1, controller can accept configuration.
- cfg_mode, input, 3, requested pattern mode.
- cfg_period, input, CNT_W, cycles per step; 0 selects CLK_DIV.
- pause, input, 1, freeze the pattern and prescaler while high.
- led, output, LED_W, registered active-low LED drive.
- step_tick, output, 1, one-cycle pulse in the cycle after each pattern advance.
- mode_cur, output, 3, currently applied mode.

Behaviour:
- Reset is asynchronous, active-low, and valid at any time, including mid-handshake or mid-step. Reset values:
  - led = all ones (all off)
  - mode_cur = 0
  - period register = CLK_DIV
  - prescaler = 0
  - pos = 0
  - dir = up
  - step_tick = 0
  - cfg_ready = 1
  - FSM = RUN
- FSM states:
  - RUN: prescaler counts.
  - HOLD: paused.
  - APPLY: one-cycle configuration load.
- Transitions:
  - RUN → HOLD when pause = 1.
  - HOLD → RUN when pause = 0.
  - RUN or HOLD → APPLY when cfg_valid & cfg_ready.
  - APPLY → HOLD if pause = 1, else → RUN.
  - cfg accept has priority over pause transitions.
- Handshake:
  - cfg_ready = 1 in RUN and HOLD, 0 in APPLY.
  - Accept happens on a clk edge with cfg_valid & cfg_ready. Mode and period are captured at that edge.
  - Holding cfg_valid high causes back-to-back accepts every 2 cycles.
- APPLY cycle actions:
  - prescaler = 0, pos = 0, dir = up.
  - led = first pattern of the new mode at the end of APPLY.
  - mode_cur updated.
  - No step_tick.
- Prescaler:
  - Counts only in RUN.
  - When prescaler == period-1: prescaler = 0, pattern advances, step_tick = 1 next cycle.
  - period = 1 gives a step every RUN cycle.
  - HOLD freezes the count; it resumes from the held value.
- Simultaneous events:
  - A cfg accept in the same cycle as a terminal count suppresses that step.
  - pause rising in the same cycle as a terminal count also suppresses the step; the prescaler holds at period-1.
- Patterns, with pos and led sampled at each step:
  - Mode 0 OFF: led = all ones; pos unused.
  - Mode 1 ROT_L: led = ~(1 << pos); pos increments and wraps LED_W-1 → 0. Sequence for LED_W = 4: 1110, 1101, 1011, 0111, 1110, …
  - Mode 2 ROT_R: led = ~(1 << (LED_W-1-pos)), same pos sequencing.
  - Mode 3 BOUNCE: led = ~(1 << pos); pos 0 → LED_W-1 → 0 with endpoints not repeated. Sequence: 0, 1, 2, 3, 2, 1, 0, 1, …; dir flips at the ends.
  - Mode 4 BLINK: alternates all zeros (on) and all ones (off), starting on.
  - Mode 5 COUNT: LED_W-bit up counter; led = ~count; wraps from all ones to 0.
  - Modes 6, 7: reserved; behave as OFF, and mode_cur reports the raw value.
- Arithmetic: the prescaler is unsigned CNT_W bits. cfg_period wider than the counter range is impossible by construction.

Test Plan:
- Reset release, no cfg, CLK_DIV overridden to 4 → led = 1111 and mode_cur = 0 permanently. step_tick pulses every 4 cycles while led is unchanged.
- Accept mode 1, period 3 → cfg_ready is 0 for one cycle. led = 1110 after APPLY, then 1101, 1011, 0111, 1110 every 3 cycles, with step_tick the cycle after each change.
- Mode 3, period 1 → led steps 1110, 1101, 1011, 0111, 1011, 1101, 1110, 1101 on consecutive cycles.
- Mode 5, period 2, 16 steps → led goes from 1111 down to 0000 and wraps to 1111; pause high for 10 cycles mid-run → led and prescaler frozen, and resume keeps the remaining count.
- cfg_valid asserted in the exact cycle of a terminal count with mode 4 → the step is suppressed, led = 0000 after APPLY, and no step_tick occurs. cfg_valid held high → an accept every 2 cycles.
- nrst asserted mid-APPLY and mid-period with mode 2 running → led = 1111 and cfg_ready = 1 immediately (asynchronous), with no step_tick until a full CLK_DIV period has elapsed after release.
